// File: rtl/div32_unit_if.sv
// Handshake/bus bundle between the execute pipeline and the multi-cycle divider.
`timescale 1ns/1ps
interface div32_unit_if;
    logic signed [31:0] data_operandA;
    logic signed [31:0] data_operandB;
    logic               ctrl_div;
    logic signed [31:0] data_result;
    logic               data_exception;
    logic               data_resultRDY;
    logic               busy;

    modport master (
        output data_operandA, data_operandB, ctrl_div,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_div,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/div32_unit.sv
// Sequential signed 32-bit restoring divider: one quotient bit per cycle,
// registered result with a one-cycle ready pulse and exception flag.
`timescale 1ns/1ps
module div32_unit (
    input logic         clock,
    input logic         resetn,
    div32_unit_if.slave bus
);
    localparam int DATA_W = 32;
    localparam logic signed [DATA_W-1:0] INT_MIN = 32'sh8000_0000;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state, state_n;
    logic [DATA_W-1:0]        quo, quo_n;
    logic [DATA_W-1:0]        dvs, dvs_n;
    logic [DATA_W:0]          rem, rem_n;
    logic                     sign, sign_n;
    logic [5:0]               cnt, cnt_n;
    logic signed [DATA_W-1:0] result, result_n;
    logic                     exc, exc_n;
    logic                     rdy, busy_q;

    logic [DATA_W:0]          rem_sh;
    logic [DATA_W-1:0]        quo_sh;
    logic signed [DATA_W:0]   trial;

    // Magnitude on 32 unsigned bits so INT_MIN maps to 0x80000000.
    function automatic logic [DATA_W-1:0] abs_u(input logic signed [DATA_W-1:0] v);
        logic [DATA_W-1:0] uv;
        uv = v;
        return v[DATA_W-1] ? (~uv + 1'b1) : uv;
    endfunction

    function automatic logic signed [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] mag,
                                                            input logic neg);
        logic [DATA_W-1:0] r;
        r = neg ? (~mag + 1'b1) : mag;
        return signed'(r);
    endfunction

    always_comb begin
        rem_sh   = {rem[DATA_W-1:0], quo[DATA_W-1]};
        quo_sh   = {quo[DATA_W-2:0], 1'b0};
        trial    = signed'(rem_sh - {1'b0, dvs});

        state_n  = state;
        quo_n    = quo;
        dvs_n    = dvs;
        rem_n    = rem;
        sign_n   = sign;
        cnt_n    = cnt;
        result_n = result;
        exc_n    = exc;

        // A start strobe wins in every state: IDLE start, DONE back-to-back, RUN abort.
        if (bus.ctrl_div) begin
            cnt_n = '0;
            if (bus.data_operandB == '0) begin
                state_n  = DONE;
                result_n = '0;
                exc_n    = 1'b1;
            end else if (bus.data_operandA == INT_MIN && bus.data_operandB == '1) begin
                state_n  = DONE;
                result_n = INT_MIN;
                exc_n    = 1'b1;
            end else begin
                quo_n   = abs_u(bus.data_operandA);
                dvs_n   = abs_u(bus.data_operandB);
                rem_n   = '0;
                sign_n  = bus.data_operandA[DATA_W-1] ^ bus.data_operandB[DATA_W-1];
                state_n = RUN;
            end
        end else begin
            case (state)
                RUN: begin
                    rem_n = trial[DATA_W] ? rem_sh : unsigned'(trial);
                    quo_n = {quo_sh[DATA_W-1:1], ~trial[DATA_W]};
                    cnt_n = cnt + 1'b1;
                    if (cnt == 6'd31) begin
                        state_n  = DONE;
                        result_n = apply_sign(quo_n, sign);
                        exc_n    = 1'b0;
                    end
                end
                DONE:    state_n = IDLE;
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            quo    <= '0;
            dvs    <= '0;
            rem    <= '0;
            sign   <= 1'b0;
            cnt    <= '0;
            result <= '0;
            exc    <= 1'b0;
            rdy    <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            quo    <= quo_n;
            dvs    <= dvs_n;
            rem    <= rem_n;
            sign   <= sign_n;
            cnt    <= cnt_n;
            result <= result_n;
            exc    <= exc_n;
            rdy    <= (state_n == DONE);
            busy_q <= (state_n == RUN);
        end
    end

    assign bus.data_result    = result;
    assign bus.data_exception = exc;
    assign bus.data_resultRDY = rdy;
    assign bus.busy           = busy_q;
endmodule

// File: tb/tb_div32_unit.sv
// Scoreboard bench for div32_unit: directed divisions with hand-computed quotients.
`timescale 1ns/1ps
module tb_div32_unit;
    logic clock = 1'b0;
    logic resetn = 1'b0;

    div32_unit_if bus ();

    div32_unit dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [31:0] last_res = '0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        exp_t e;
        if (resetn && bus.data_resultRDY === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rdy: got RDY at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                check("result", bus.data_result, e.res);
                check("exception", {31'b0, bus.data_exception}, {31'b0, e.exc});
                check("rdy_cycle", cyc, e.cyc);
            end
        end
    end

    // Caller is positioned before a negedge-to-posedge window; this drives and samples one edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic exc, input bit push);
        exp_t e;
        bus.data_operandA = a;
        bus.data_operandB = b;
        bus.ctrl_div      = 1'b1;
        @(posedge clock);
        #1 bus.ctrl_div = 1'b0;
        if (push) begin
            e.res = res;
            e.exc = exc;
            e.cyc = exc ? cyc : cyc + 32;
            sb.push_back(e);
        end
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic exc, input bit push);
        @(negedge clock);
        issue(a, b, res, exc, push);
    endtask

    task automatic wait_done(output int busy_cnt);
        busy_cnt = 0;
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin
            @(negedge clock);
            if (bus.busy === 1'b1) busy_cnt++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic exc);
        int bc;
        start(a, b, res, exc, 1'b1);
        wait_done(bc);
        check({name, "_busy_cycles"}, bc, exc ? 32'd0 : 32'd32);
        last_res = res;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish by 100000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int  bc;
        bit  got;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        bus.ctrl_div      = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_result", bus.data_result, 32'h0);
        check("reset_exc", {31'b0, bus.data_exception}, 32'h0);
        check("reset_rdy", {31'b0, bus.data_resultRDY}, 32'h0);
        check("reset_busy", {31'b0, bus.busy}, 32'h0);
        @(negedge clock);
        resetn = 1'b1;

        run_op("p100_d7",   32'd100,        32'd7,          32'h0000_000E, 1'b0);
        run_op("m100_d7",   -32'sd100,      32'd7,          32'hFFFF_FFF2, 1'b0);
        run_op("p100_dm7",  32'd100,        -32'sd7,        32'hFFFF_FFF2, 1'b0);
        run_op("m100_dm7",  -32'sd100,      -32'sd7,        32'h0000_000E, 1'b0);
        run_op("min_d2",    32'h8000_0000,  32'd2,          32'hC000_0000, 1'b0);
        run_op("div_zero",  32'd7,          32'd0,          32'h0000_0000, 1'b1);
        run_op("overflow",  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1'b1);
        run_op("p9_d3",     32'd9,          32'd3,          32'h0000_0003, 1'b0);

        // Abort 100/7 at relative edge 10 with 50/5; result must hold until the new RDY.
        start(32'd100, 32'd7, 32'h0, 1'b0, 1'b0);
        repeat (9) @(posedge clock);
        #1 check("restart_hold_early", bus.data_result, last_res);
        start(32'd50, 32'd5, 32'h0000_000A, 1'b0, 1'b1);
        repeat (25) @(posedge clock);
        #1 check("restart_hold_late", bus.data_result, last_res);
        wait_done(bc);
        last_res = 32'h0000_000A;

        // Asynchronous reset mid-run at relative edge 15.
        start(32'd100, 32'd7, 32'h0, 1'b0, 1'b0);
        repeat (15) @(posedge clock);
        #2 resetn = 1'b0;
        #1;
        check("midreset_result", bus.data_result, 32'h0);
        check("midreset_exc", {31'b0, bus.data_exception}, 32'h0);
        check("midreset_rdy", {31'b0, bus.data_resultRDY}, 32'h0);
        check("midreset_busy", {31'b0, bus.busy}, 32'h0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        repeat (40) @(negedge clock);
        check("postreset_busy", {31'b0, bus.busy}, 32'h0);
        run_op("p6_d3",     32'd6,          32'd3,          32'h0000_0002, 1'b0);

        run_op("p5_d9",     32'd5,          32'd9,          32'h0000_0000, 1'b0);
        run_op("m1_d1",     32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF, 1'b0);
        run_op("max_d1",    32'h7FFF_FFFF,  32'd1,          32'h7FFF_FFFF, 1'b0);
        run_op("max_dmax",  32'h7FFF_FFFF,  32'h7FFF_FFFF,  32'h0000_0001, 1'b0);

        // Back-to-back: second start sampled on the edge that leaves DONE.
        start(32'd20, 32'd4, 32'h0000_0005, 1'b0, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clock);
            got = (bus.data_resultRDY === 1'b1);
        end
        check("b2b_first_rdy", {31'b0, got}, 32'h1);
        issue(32'd21, -32'sd3, 32'hFFFF_FFF9, 1'b0, 1'b1);
        wait_done(bc);
        check("b2b_busy_cycles", bc, 32'd32);

        repeat (3) @(negedge clock);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/div32_unit.md
# div32_unit

Multi-cycle signed 32-bit divider for the CPU execute stage, the sequential counterpart to the single-cycle bitwise ALU operators. The pipeline pulses a start strobe, the block captures both operands and computes one quotient bit per cycle. It then returns the quotient with a one-cycle ready pulse and an exception flag. The pipeline stalls on `busy`, and the writeback path consumes `data_result` on `data_resultRDY`.

## Interface
- `clock`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `data_operandA`  in  32  dividend, two's complement; sampled only on the start edge.
- `data_operandB`  in  32  divisor, two's complement; sampled only on the start edge.
- `ctrl_div`  in  1  start strobe; sampled every rising edge.
- `data_result`  out  32  quotient; holds its value until the next completion.
- `data_exception`  out  1  divide-by-zero or overflow flag; valid and held with `data_result`.
- `data_resultRDY`  out  1  completion pulse, high for exactly one cycle.
- `busy`  out  1  high while in RUN.

## Operation
- Reset (`resetn`=0, any time, asynchronous): state=IDLE, `data_result`=0, `data_exception`=0, `data_resultRDY`=0, `busy`=0, counter=0, internal regs=0. Reset mid-operation abandons the division; no RDY is produced.
- States: IDLE, RUN, DONE.
- IDLE, `ctrl_div`=1: capture the operands.
  - If B==0, go to DONE with result=0 and exception=1.
  - If A==0x80000000 and B==0xFFFFFFFF, go to DONE with result=0x80000000 and exception=1.
  - Otherwise load |A| into the quotient register, |B| into the divisor register, 0 into the 33-bit remainder register, and sign = A[31]^B[31]. Set counter=0 and go to RUN.
- RUN, each edge: shift {rem,quo} left by 1. Compute trial = rem − divisor at 33 bits. If trial ≥ 0, rem = trial and quo[0] = 1; else quo[0] = 0. Increment the counter.
- RUN, on the 32nd iteration edge: go to DONE.
- RUN → DONE transfer: result = sign ? −quo : quo (two's complement, 32-bit wrap), exception=0. The remainder is discarded.
- DONE: `data_resultRDY`=1 for this single cycle. Next edge returns to IDLE. If `ctrl_div`=1 on that edge, it is treated exactly as an IDLE start.
- `ctrl_div`=1 while in RUN: abort and restart. Capture the new operands under the same IDLE rules, reset the counter, produce no RDY for the aborted operation, and leave `data_result` unchanged.
- Quotient truncates toward zero. |A| is computed on 32 bits unsigned, so |0x80000000| = 0x80000000 is correct.
- `data_result` and `data_exception` change only on entry to DONE or on reset.

## Timing
- Number edges with the edge that samples `ctrl_div`=1 as edge 0.
- Normal division: `busy` is high after edge 0 through edge 32. DONE is entered at edge 32, so `data_resultRDY` is high between edges 32 and 33. Start-to-ready latency is 32 cycles.
- Exception cases: DONE is entered at edge 0, so `data_resultRDY` is high between edges 0 and 1. Latency is 1 cycle and `busy` never rises.
- Restart at RUN edge k: the new operation's edge 0 is k, and RDY follows at k+32.
- Back-to-back: a start sampled while in DONE gives the next RDY 32 cycles later. Minimum issue interval is 33 cycles for normal divisions.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- 100 / 7: start at edge 0 → RDY only between edges 32 and 33, result=14 (0x0000000E), exception=0, `busy` high for 32 cycles.
- −100 / 7 → result 0xFFFFFFF2. Also 100 / −7 → 0xFFFFFFF2, −100 / −7 → 0x0000000E, and 0x80000000 / 2 → 0xC0000000. All with exception=0.
- 7 / 0 → RDY one cycle after start, result=0, exception=1, `busy`=0. Then 0x80000000 / 0xFFFFFFFF → result 0x80000000, exception=1. Then 9 / 3 → result 3 with exception cleared.
- Restart: start 100/7, then assert `ctrl_div` with 50/5 at edge 10 → no RDY at edge 32, single RDY between edges 42 and 43 with result=10. `data_result` retains its prior value until then.
- Reset: deassert `resetn` mid-RUN at edge 15 → all outputs 0 immediately, no RDY ever. Start 6/3 after release → result 2 at normal latency.
- Edge values: 5/9 → 0; 0xFFFFFFFF/1 → 0xFFFFFFFF; 0x7FFFFFFF/1 → 0x7FFFFFFF; 0x7FFFFFFF/0x7FFFFFFF → 1. Back-to-back start during DONE yields RDY exactly 32 cycles later.
